// File: rtl/scan_shift_ctl_if.sv
// Host and scan-chain signal bundle for scan_shift_ctl.
// master = test host/chain side, slave = sequencer side.
interface scan_shift_ctl_if #(
  parameter int CHAIN_LEN = 64
);
  logic                 start;
  logic                 cap_en;
  logic [CHAIN_LEN-1:0] pat;
  logic [CHAIN_LEN-1:0] exp;
  logic [CHAIN_LEN-1:0] mask;
  logic                 scan_out0;
  logic                 scan_en;
  logic                 scan_in0;
  logic [CHAIN_LEN-1:0] resp;
  logic                 busy;
  logic                 done;
  logic                 mismatch;

  modport master (
    output start, cap_en, pat, exp, mask, scan_out0,
    input  scan_en, scan_in0, resp, busy, done, mismatch
  );

  modport slave (
    input  start, cap_en, pat, exp, mask, scan_out0,
    output scan_en, scan_in0, resp, busy, done, mismatch
  );
endinterface

// File: rtl/scan_shift_ctl.sv
// Scan load/capture/unload sequencer for one chain segment.
// Ports: clk, reset (sync, active-high), bus (slave modport).
module scan_shift_ctl #(
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = 8
) (
  input logic          clk,
  input logic          reset,
  scan_shift_ctl_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SHIFT  = 3'd1;
  localparam logic [2:0] S_CAP    = 3'd2;
  localparam logic [2:0] S_UNLOAD = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(CHAIN_LEN - 1);

  logic [2:0]           state;
  logic [2:0]           state_n;
  logic [CNT_W-1:0]     cnt;
  logic                 last;
  logic                 cap_q;
  logic [CHAIN_LEN-1:0] sh_q;
  logic [CHAIN_LEN-1:0] resp_q;
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] mask_q;
  logic                 scan_en_q;
  logic                 busy_q;
  logic                 done_q;

  assign last = (cnt == LAST);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (bus.start) state_n = S_SHIFT;
      S_SHIFT:  if (last)
                  state_n = cap_q ? S_CAP : S_UNLOAD;
      S_CAP:    state_n = S_UNLOAD;
      S_UNLOAD: if (last) state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so
  // they line up with the state they describe.
  // sh_q empties itself while shifting, so its LSB
  // is also the idle/capture/unload zero on scan_in0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cap_q     <= 1'b0;
      sh_q      <= '0;
      resp_q    <= '0;
      exp_q     <= '0;
      mask_q    <= '0;
      scan_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      scan_en_q <= (state_n == S_SHIFT) ||
                   (state_n == S_UNLOAD);
      busy_q    <= (state_n == S_SHIFT) ||
                   (state_n == S_CAP)   ||
                   (state_n == S_UNLOAD);
      done_q    <= (state_n == S_DONE);

      if (state_n != state || state == S_IDLE)
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);

      if (state == S_IDLE && bus.start) begin
        sh_q   <= bus.pat;
        cap_q  <= bus.cap_en;
        exp_q  <= bus.exp;
        mask_q <= bus.mask;
        resp_q <= '0;
      end else if (state == S_SHIFT) begin
        sh_q <= sh_q >> 1;
      end

      // Tail bit enters at the top; after the last
      // unload cycle the first bit read sits at bit 0.
      if (state == S_UNLOAD)
        resp_q <= {bus.scan_out0,
                   resp_q[CHAIN_LEN-1:1]};
    end
  end

  assign bus.scan_en  = scan_en_q;
  assign bus.scan_in0 = sh_q[0];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.resp     = resp_q;
  assign bus.mismatch =
    |((resp_q ^ exp_q) & mask_q);

endmodule

// File: tb/tb_scan_shift_ctl.sv
// Self-checking bench for scan_shift_ctl.
// Drives an 8-flop chain model that inverts on capture.
module tb_scan_shift_ctl;

  localparam int N     = 8;
  localparam int BOUND = 60;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total  = 0;
  int   cyc_ctr = 0;

  logic en_log [0:63];
  logic in_log [0:63];

  logic [N-1:0] chain = '0;

  scan_shift_ctl_if #(.CHAIN_LEN(N)) bus ();

  scan_shift_ctl #(
    .CHAIN_LEN(N),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  // Ideal chain: shifts toward the tail (bit 0) when
  // enabled; functional capture stores the inverse.
  always @(posedge clk) begin
    if (bus.scan_en)
      chain <= {bus.scan_in0, chain[N-1:1]};
    else if (bus.busy)
      chain <= ~chain;
  end

  assign bus.scan_out0 = chain[0];

  task automatic run_seq(
    input  logic [N-1:0] p,
    input  logic [N-1:0] e,
    input  logic [N-1:0] m,
    input  logic         c,
    output int           dcyc
  );
    @(negedge clk);
    bus.pat = p; bus.exp = e;
    bus.mask = m; bus.cap_en = c;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    dcyc = -1;
    for (int cyc = 1; cyc <= BOUND; cyc++) begin
      en_log[cyc] = bus.scan_en;
      in_log[cyc] = bus.scan_in0;
      if (bus.done) begin
        dcyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.cap_en = 1'b0;
    bus.pat = '0; bus.exp = '0; bus.mask = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.scan_en, bus.scan_in0, bus.busy,
         bus.done} !== 4'b0)
      $display("FAIL reset_ctl got %b want 0000",
        {bus.scan_en, bus.scan_in0,
         bus.busy, bus.done});
    else passed++;
    total++;
    if (bus.resp !== '0 || bus.mismatch !== 1'b0)
      $display("FAIL reset_resp got %h/%b want 00/0",
        bus.resp, bus.mismatch);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_integrity();
    int d;
    run_seq(8'hA5, 8'hA5, 8'hFF, 1'b0, d);
    total++;
    if (d !== 17)
      $display("FAIL integ_done got %0d want 17", d);
    else passed++;
    total++;
    if (bus.resp !== 8'hA5)
      $display("FAIL integ_resp got %h want a5",
        bus.resp);
    else passed++;
    total++;
    if (bus.mismatch !== 1'b0)
      $display("FAIL integ_mm got %b want 0",
        bus.mismatch);
    else passed++;
  endtask

  task automatic test_capture();
    int d;
    run_seq(8'h3C, 8'hC3, 8'hFF, 1'b1, d);
    total++;
    if (d !== 18)
      $display("FAIL cap_done got %0d want 18", d);
    else passed++;
    total++;
    if (bus.resp !== 8'hC3)
      $display("FAIL cap_resp got %h want c3",
        bus.resp);
    else passed++;
    total++;
    if (bus.mismatch !== 1'b0)
      $display("FAIL cap_mm0 got %b want 0",
        bus.mismatch);
    else passed++;
    run_seq(8'h3C, 8'hC2, 8'hFF, 1'b1, d);
    total++;
    if (bus.mismatch !== 1'b1)
      $display("FAIL cap_mm1 got %b want 1",
        bus.mismatch);
    else passed++;
  endtask

  task automatic test_mask();
    int d;
    run_seq(8'hF0, 8'h00, 8'h0F, 1'b0, d);
    total++;
    if (bus.mismatch !== 1'b0)
      $display("FAIL mask_0f got %b want 0",
        bus.mismatch);
    else passed++;
    run_seq(8'hF0, 8'h00, 8'h1F, 1'b0, d);
    total++;
    if (bus.mismatch !== 1'b1)
      $display("FAIL mask_1f got %b want 1",
        bus.mismatch);
    else passed++;
  endtask

  task automatic test_busy_protect();
    int d;
    d = -1;
    @(negedge clk);
    bus.pat = 8'hAA; bus.exp = 8'hAA;
    bus.mask = 8'hFF; bus.cap_en = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= BOUND; cyc++) begin
      if (bus.done) begin
        d = cyc;
        break;
      end
      if (cyc == 5) begin
        bus.pat = 8'h55; bus.exp = 8'h55;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    total++;
    if (d !== 17)
      $display("FAIL busy_done got %0d want 17", d);
    else passed++;
    total++;
    if (bus.resp !== 8'hAA || bus.mismatch !== 1'b0)
      $display("FAIL busy_resp got %h/%b want aa/0",
        bus.resp, bus.mismatch);
    else passed++;
    // start during the DONE cycle must be dropped
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.scan_en !== 1'b0)
      $display("FAIL done_start got busy=%b en=%b want 0 0",
        bus.busy, bus.scan_en);
    else passed++;
    total++;
    if (bus.resp !== 8'hAA)
      $display("FAIL done_hold got %h want aa",
        bus.resp);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int d;
    logic [N-1:0] p;
    p = N'($urandom);
    @(negedge clk);
    bus.pat = 8'h5A; bus.exp = 8'h00;
    bus.mask = 8'hFF; bus.cap_en = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({bus.scan_en, bus.busy, bus.done,
         bus.scan_in0} !== 4'b0)
      $display("FAIL rst_mid_ctl got %b want 0000",
        {bus.scan_en, bus.busy, bus.done,
         bus.scan_in0});
    else passed++;
    total++;
    if (bus.resp !== '0 || bus.mismatch !== 1'b0)
      $display("FAIL rst_mid_resp got %h/%b want 00/0",
        bus.resp, bus.mismatch);
    else passed++;
    run_seq(p, p, 8'hFF, 1'b0, d);
    total++;
    if (d !== 17 || bus.resp !== p)
      $display("FAIL rst_restart got %0d/%h want 17/%h",
        d, bus.resp, p);
    else passed++;
    // start together with reset: reset wins
    @(negedge clk);
    bus.start = 1'b1; reset = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; reset = 1'b0;
    total++;
    if (bus.busy !== 1'b0)
      $display("FAIL rst_start got %b want 0",
        bus.busy);
    else passed++;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || bus.scan_en !== 1'b0)
      $display("FAIL rst_start2 got %b%b want 00",
        bus.busy, bus.scan_en);
    else passed++;
  endtask

  task automatic test_scan_timing();
    int d;
    int lows;
    logic [N-1:0] p;
    p = N'($urandom);
    run_seq(p, ~p, 8'hFF, 1'b1, d);
    total++;
    if (d !== 2 * N + 2)
      $display("FAIL tim_done got %0d want %0d",
        d, 2 * N + 2);
    else passed++;
    if (d > 0) begin
      for (int k = 0; k < N; k++) begin
        total++;
        if (en_log[k+1] !== 1'b1 ||
            in_log[k+1] !== p[k])
          $display("FAIL tim_shift%0d got %b%b want 1%b",
            k, en_log[k+1], in_log[k+1], p[k]);
        else passed++;
      end
      total++;
      if (en_log[N+1] !== 1'b0 ||
          in_log[N+1] !== 1'b0)
        $display("FAIL tim_cap got %b%b want 00",
          en_log[N+1], in_log[N+1]);
      else passed++;
      lows = 0;
      for (int c = 1; c < d; c++)
        if (en_log[c] !== 1'b1) lows++;
      total++;
      if (lows !== 1)
        $display("FAIL tim_lowcnt got %0d want 1",
          lows);
      else passed++;
    end
    total++;
    if (bus.resp !== ~p || bus.mismatch !== 1'b0)
      $display("FAIL tim_resp got %h/%b want %h/0",
        bus.resp, bus.mismatch, ~p);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int d;
    int prev;
    int now;
    logic [N-1:0] p, e, m, r;
    logic c, mm;
    prev = -1;
    for (int i = 0; i < 20; i++) begin
      p = N'($urandom);
      m = N'($urandom);
      c = 1'($urandom);
      r = c ? ~p : p;
      e = ($urandom_range(0, 1) == 1) ? r
          : (r ^ N'(1 << $urandom_range(0, N - 1)));
      mm = ((r ^ e) & m) != '0;
      run_seq(p, e, m, c, d);
      now = cyc_ctr;
      total++;
      if (d !== 2 * N + 1 + int'(c))
        $display("FAIL b2b_done%0d got %0d want %0d",
          i, d, 2 * N + 1 + int'(c));
      else passed++;
      total++;
      if (bus.resp !== r || bus.mismatch !== mm)
        $display("FAIL b2b_resp%0d got %h/%b want %h/%b",
          i, bus.resp, bus.mismatch, r, mm);
      else passed++;
      if (prev >= 0) begin
        total++;
        if (now - prev !== 2 * N + 2 + int'(c))
          $display("FAIL b2b_period%0d got %0d want %0d",
            i, now - prev, 2 * N + 2 + int'(c));
        else passed++;
      end
      prev = now;
    end
  endtask

  initial begin
    test_reset();
    test_integrity();
    test_capture();
    test_mask();
    test_busy_protect();
    test_reset_mid();
    test_scan_timing();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/scan_shift_ctl.md
# scan_shift_ctl

Scan-test sequencer that drives the `scan_in0`/`scan_en` side of a block's scan chain and collects `scan_out0`, i.e. the initiator end of the scan interface exposed by the MCAC datapath blocks. A load/capture/unload cycle moves a parallel pattern serially into the chain, optionally pulses one functional capture cycle, shifts the chain contents back out into a parallel response register, and compares them against a masked expected value. It sits between the test host (register interface or bench) and one scan-chain segment.

## Interface
- `CHAIN_LEN`, 64: scan-chain length in flops; legal range 2..256.
- `CNT_W`, 8: shift-counter width; must satisfy 2^CNT_W >= CHAIN_LEN.
- `clk`  in  1: single clock; the DUT chain shifts on the same edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request one load/capture/unload sequence.
- `cap_en`  in  1: 1 = insert the capture cycle; 0 = pure shift-through (chain integrity).
- `pat`  in  CHAIN_LEN: pattern to load.
- `exp`  in  CHAIN_LEN: expected response.
- `mask`  in  CHAIN_LEN: compare mask; 1 = bit checked.
- `scan_out0`  in  1: serial data from the chain tail.
- `scan_en`  out  1: chain shift enable to the DUT.
- `scan_in0`  out  1: serial data to the chain head.
- `resp`  out  CHAIN_LEN: unloaded response.
- `busy`  out  1: sequence in progress.
- `done`  out  1: one-cycle completion pulse.
- `mismatch`  out  1: `|((resp ^ exp_q) & mask_q)`; valid from `done`.

## Operation
- States: IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
- IDLE: `scan_en`=0, `scan_in0`=0, `busy`=0. `start`=1 latches `pat`, `exp`, `mask` and `cap_en`, clears the counter, and moves to SHIFT. `start` in any other state is ignored.
- SHIFT: `scan_en`=1. `scan_in0` = `pat_q[k]` on shift cycle k (k=0..CHAIN_LEN-1, LSB first). `scan_out0` is ignored. After CHAIN_LEN cycles, go to CAPTURE if `cap_en_q`, else go to UNLOAD.
- CAPTURE: exactly one cycle with `scan_en`=0 and `scan_in0`=0. The DUT performs its functional capture. Next state is UNLOAD.
- UNLOAD: `scan_en`=1, `scan_in0`=0. On unload cycle k, the value present on `scan_out0` is written into `resp[k]`, so `resp[0]` is the chain tail. After CHAIN_LEN cycles, go to DONE.
- DONE: one cycle with `done`=1, `busy`=0, `scan_en`=0. `mismatch` is computed combinationally from the registered `resp`/`exp_q`/`mask_q`. Next state is IDLE.
- Bit ordering: with `cap_en`=0 and an ideal chain, `resp` == `pat`.
- `resp`, `exp_q`, `mask_q` and therefore `mismatch` hold their values until the next accepted `start`. `start` clears `resp` to 0.
- Counter: CNT_W bits, wraps to 0 on every phase change. A terminal-count compare against CHAIN_LEN-1 ends each phase.
- Reset (any state, including mid-SHIFT or mid-UNLOAD) forces IDLE on the next edge. Reset values: `scan_en`=0, `scan_in0`=0, `busy`=0, `done`=0, `resp`=0, `exp_q`=0, `mask_q`=0, so `mismatch`=0. The partially loaded DUT chain is not restored.
- `start` together with `reset`: reset wins and the start is dropped.
- `start` asserted in the DONE cycle: ignored. `start` asserted in the following IDLE cycle: accepted.

## Timing
- All outputs are registered except `mismatch`, which is combinational from registers.
- `start` sampled high at edge 0. SHIFT occupies cycles 1..N (N = CHAIN_LEN). CAPTURE occupies cycle N+1 when `cap_en`=1. UNLOAD follows for N cycles. DONE falls on cycle 2N+2 with capture, 2N+1 without.
- `busy` is 1 from cycle 1 through the last UNLOAD cycle.
- Back-to-back throughput: one sequence every 2N+3 cycles with capture, 2N+2 without.

## Test plan
- Integrity, CHAIN_LEN=8, ideal 8-flop chain model, `cap_en`=0, `pat`=8'hA5, `exp`=8'hA5, `mask`=8'hFF: expect `resp`=8'hA5, `done` on cycle 17, `mismatch`=0.
- Capture, chain model that captures its inverted contents, `cap_en`=1, `pat`=8'h3C, `exp`=8'hC3: expect `done` on cycle 18, `resp`=8'hC3, `mismatch`=0. With `exp`=8'hC2, expect `mismatch`=1.
- Mask, `cap_en`=0, `pat`=8'hF0, `exp`=8'h00, `mask`=8'h0F: expect `mismatch`=0. With `mask`=8'h1F, expect `mismatch`=1.
- Busy protection: `start` pulsed with `pat`=8'h55 on cycle 5 of a running sequence with `pat`=8'hAA: expect it ignored and `resp`=8'hAA.
- Reset mid-UNLOAD (cycle 12): expect `scan_en`=0, `busy`=0, `resp`=0 and `mismatch`=0 on the next edge. A new `start` then completes normally.
- Scan timing check: `scan_en` low during CAPTURE for exactly one cycle, and `scan_in0` equal to `pat[k]` on every SHIFT cycle k.
